// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_pkg
//  Purpose  : Shared types and default widths for the data-memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_mem_pkg;

    localparam int DMEM_DW = 32;
    localparam int DMEM_AW = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CORE = 2'd1,
        LDR_ACK = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_LDR  = 2'd2
    } grant_t;

endpackage : riscv_mem_pkg
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : arb_starve_cnt
//  Purpose  : Saturating count of consecutive arbitration losses by the
//             loader; sat tells the arbiter to force a loader grant.
//  Revision : 1.0  initial release
// ============================================================================
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] r_cnt;

    // Clear has priority; increment stops at the ceiling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sat = (r_cnt == C_MAX);

endmodule : arb_starve_cnt
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares the single-port data RAM between the core load/store
//             port and the loader/debug port, sequencing the 1-cycle read
//             latency and generating core stall / read-return signals.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int DW         = DMEM_DW,
    parameter int AW         = DMEM_AW,
    parameter int STARVE_MAX = 4
) (
    input  logic          reloj,
    input  logic          reset,
    input  logic          core_rd_req,
    input  logic          core_wr_req,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic          ram_ena_rd,
    output logic          ram_ena_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    grant_t     w_grant;
    logic       r_ldr_is_rd;
    logic       w_core_req;
    logic       w_sat;
    logic       w_starve_inc;
    logic       w_starve_clr;

    assign w_core_req = core_rd_req | core_wr_req;

    // Counter only moves while arbitrating in IDLE; held in the other states.
    assign w_starve_inc = reset && (r_state == IDLE) && ldr_req && (w_grant == GNT_CORE);
    assign w_starve_clr = reset && (r_state == IDLE) && ((w_grant == GNT_LDR) || !ldr_req);

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk   (reloj),
        .rst_n (reset),
        .inc   (w_starve_inc),
        .clr   (w_starve_clr),
        .sat   (w_sat)
    );

    // State register plus a flag remembering whether the loader op was a read.
    always_ff @(posedge reloj) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ldr_is_rd <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant == GNT_LDR) begin
                r_ldr_is_rd <= !ldr_we;
            end
        end
    end

    // Arbitration, RAM command and response outputs; everything is forced
    // to zero while reset is held so the RAM sees no stray enables.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = GNT_NONE;
        ram_ena_rd  = 1'b0;
        ram_ena_wr  = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        core_stall  = 1'b0;
        core_rvalid = 1'b0;
        core_rdata  = '0;
        ldr_ack     = 1'b0;
        ldr_rdata   = '0;
        if (reset) begin
            core_stall = w_core_req;
            case (r_state)
                IDLE: begin
                    if (ldr_req && (!w_core_req || w_sat)) begin
                        w_grant = GNT_LDR;
                    end else if (w_core_req) begin
                        w_grant = GNT_CORE;
                    end
                    if (w_grant == GNT_LDR) begin
                        ram_addr    = ldr_addr;
                        ram_din     = ldr_wdata;
                        ram_ena_wr  = ldr_we;
                        ram_ena_rd  = !ldr_we;
                        w_state_nxt = LDR_ACK;
                    end else if (w_grant == GNT_CORE) begin
                        ram_addr = core_addr;
                        ram_din  = core_wdata;
                        // A simultaneous read request is dropped in favour of the store.
                        if (core_wr_req) begin
                            ram_ena_wr = 1'b1;
                            core_stall = 1'b0;
                        end else begin
                            ram_ena_rd  = 1'b1;
                            w_state_nxt = RD_CORE;
                        end
                    end
                end
                RD_CORE: begin
                    core_stall  = 1'b0;
                    core_rvalid = 1'b1;
                    core_rdata  = ram_dout;
                    w_state_nxt = IDLE;
                end
                LDR_ACK: begin
                    ldr_ack     = 1'b1;
                    ldr_rdata   = r_ldr_is_rd ? ram_dout : '0;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed stimulus for dmem_arbiter with a transaction-level
//             reference model checked every cycle, plus literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SMAX = 4;

    logic          reloj = 1'b0;
    logic          reset;
    logic          core_rd_req, core_wr_req;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_stall, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          ldr_req, ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;
    logic          ram_ena_rd, ram_ena_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 reloj = ~reloj;

    dmem_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX)) u_dut (
        .reloj(reloj), .reset(reset),
        .core_rd_req(core_rd_req), .core_wr_req(core_wr_req),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_ena_rd(ram_ena_rd), .ram_ena_wr(ram_ena_wr),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Behavioural single-port RAM with 1-cycle read latency.
    bit [DW-1:0] ram [1024];
    always @(posedge reloj) begin
        if (ram_ena_wr) ram[ram_addr] <= ram_din;
        if (ram_ena_rd) ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Outstanding obligations: a pending core load return and a pending
    // loader acknowledge, plus a golden copy of memory contents.
    bit [DW-1:0] m_mem [1024];
    bit          m_rv_due = 0, m_ack_due = 0;
    bit [DW-1:0] m_rv_data = 0, m_ack_data = 0;
    int          m_starve = 0;
    bit          m_busy, m_creq, m_gl, m_gc;
    logic [DW-1:0] e_rdata, e_lrd, e_din;
    logic [AW-1:0] e_addr;
    logic          e_rd, e_wr, e_stall;

    always @(negedge reloj) begin
        if (!reset) begin
            chk("rst_stall",  {31'b0, core_stall},  0);
            chk("rst_rvalid", {31'b0, core_rvalid}, 0);
            chk("rst_rdata",  core_rdata, 0);
            chk("rst_ack",    {31'b0, ldr_ack}, 0);
            chk("rst_lrdata", ldr_rdata, 0);
            chk("rst_enard",  {31'b0, ram_ena_rd}, 0);
            chk("rst_enawr",  {31'b0, ram_ena_wr}, 0);
            chk("rst_addr",   {22'b0, ram_addr}, 0);
            chk("rst_din",    ram_din, 0);
            m_rv_due = 0; m_ack_due = 0; m_starve = 0;
        end else begin
            m_busy = m_rv_due || m_ack_due;
            m_creq = core_rd_req || core_wr_req;
            m_gl = !m_busy && ldr_req && (!m_creq || m_starve >= SMAX);
            m_gc = !m_busy && !m_gl && m_creq;
            e_rd = 0; e_wr = 0; e_addr = 0; e_din = 0;
            if (m_gl) begin
                e_addr = ldr_addr; e_din = ldr_wdata; e_wr = ldr_we; e_rd = !ldr_we;
            end else if (m_gc) begin
                e_addr = core_addr; e_din = core_wdata; e_wr = core_wr_req; e_rd = !core_wr_req;
            end
            if (m_rv_due) e_stall = 0;
            else if (m_gc && core_wr_req) e_stall = 0;
            else e_stall = m_creq;
            e_rdata = m_rv_due ? m_rv_data : 0;
            e_lrd   = m_ack_due ? m_ack_data : 0;
            chk("stall",  {31'b0, core_stall},  {31'b0, e_stall});
            chk("rvalid", {31'b0, core_rvalid}, {31'b0, m_rv_due});
            chk("rdata",  core_rdata, e_rdata);
            chk("ack",    {31'b0, ldr_ack}, {31'b0, m_ack_due});
            chk("lrdata", ldr_rdata, e_lrd);
            chk("ena_rd", {31'b0, ram_ena_rd}, {31'b0, e_rd});
            chk("ena_wr", {31'b0, ram_ena_wr}, {31'b0, e_wr});
            chk("addr",   {22'b0, ram_addr}, {22'b0, e_addr});
            chk("din",    ram_din, e_din);
            // Advance the model to what holds after the coming edge.
            m_rv_due  = m_gc && !core_wr_req;
            m_rv_data = m_mem[core_addr];
            m_ack_due  = m_gl;
            m_ack_data = ldr_we ? '0 : m_mem[ldr_addr];
            if (m_gl && ldr_we) m_mem[ldr_addr] = ldr_wdata;
            if (m_gc && core_wr_req) m_mem[core_addr] = core_wdata;
            if (!m_busy) begin
                if (m_gl || !ldr_req) m_starve = 0;
                else if (m_gc) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge reloj); #1;
    endtask

    int  grants;
    bit  got_ldr;

    initial begin
        reset = 0; core_rd_req = 1; core_wr_req = 0; core_addr = 10'h000; core_wdata = 0;
        ldr_req = 1; ldr_we = 0; ldr_addr = 10'h000; ldr_wdata = 0;
        repeat (3) tick();
        @(negedge reloj); #1;
        chk("lit_rst_enard", {31'b0, ram_ena_rd}, 0);
        // Release: core requesting with starve count 0 gets the first grant.
        tick(); reset = 1;
        @(negedge reloj); #1;
        chk("lit_first_core_grant", {31'b0, ram_ena_rd}, 1);
        chk("lit_first_core_stall", {31'b0, core_stall}, 1);
        tick(); core_rd_req = 0;                 // RD_CORE return cycle
        tick();                                  // loader gets the port
        @(negedge reloj); #1;
        chk("lit_ldr_after_core", {31'b0, ram_ena_rd}, 1);
        tick();                                  // ack cycle
        tick(); ldr_req = 0;

        // Core store then load of 0x005.
        core_wr_req = 1; core_addr = 10'h005; core_wdata = 32'hDEADBEEF;
        @(negedge reloj); #1;
        chk("lit_st_stall", {31'b0, core_stall}, 0);
        tick(); core_wr_req = 0; core_rd_req = 1;
        @(negedge reloj); #1;
        chk("lit_ld_stall", {31'b0, core_stall}, 1);
        tick();
        @(negedge reloj); #1;
        chk("lit_ld_rvalid", {31'b0, core_rvalid}, 1);
        chk("lit_ld_rdata", core_rdata, 32'hDEADBEEF);
        tick(); core_rd_req = 0;

        // Loader write 0x3FF, then loader read of the same word.
        ldr_req = 1; ldr_we = 1; ldr_addr = 10'h3FF; ldr_wdata = 32'h12345678;
        @(negedge reloj); #1;
        chk("lit_lw_enawr", {31'b0, ram_ena_wr}, 1);
        tick();
        @(negedge reloj); #1;
        chk("lit_lw_ack", {31'b0, ldr_ack}, 1);
        chk("lit_lw_rdata", ldr_rdata, 0);
        tick(); ldr_we = 0;
        tick();
        @(negedge reloj); #1;
        chk("lit_lr_ack", {31'b0, ldr_ack}, 1);
        chk("lit_lr_rdata", ldr_rdata, 32'h12345678);
        tick(); ldr_req = 0;

        // Continuous stores with the loader waiting: forced grant after SMAX.
        ldr_req = 1; ldr_we = 1; ldr_addr = 10'h010; ldr_wdata = 32'h000000AA;
        core_wr_req = 1; core_wdata = 32'hC0DE0000;
        grants = 0; got_ldr = 0;
        for (int i = 0; i < 20 && !got_ldr; i++) begin
            core_addr = 10'h100 + 10'(i); core_wdata = 32'hC0DE0000 + i;
            @(negedge reloj); #1;
            if (core_stall) got_ldr = 1;
            else begin grants++; tick(); end
        end
        chk("lit_starve_got_ldr", {31'b0, got_ldr}, 1);
        chk("lit_starve_grants", grants, 4);
        chk("lit_starve_ldr_wr", {22'b0, ram_addr}, 32'h010);
        tick();
        @(negedge reloj); #1;
        chk("lit_starve_ack_stall", {31'b0, core_stall}, 1);
        chk("lit_starve_cnt_zero", 32'(u_dut.u_starve.r_cnt), 0);
        tick(); ldr_req = 0;
        @(negedge reloj); #1;
        chk("lit_core_resumes", {31'b0, core_stall}, 0);
        tick(); core_wr_req = 0;

        // Read and write requested together: store wins.
        core_rd_req = 1; core_wr_req = 1; core_addr = 10'h007; core_wdata = 32'h77;
        @(negedge reloj); #1;
        chk("lit_both_enawr", {31'b0, ram_ena_wr}, 1);
        chk("lit_both_enard", {31'b0, ram_ena_rd}, 0);
        tick(); core_rd_req = 0; core_wr_req = 0;
        @(negedge reloj); #1;
        chk("lit_both_norvalid", {31'b0, core_rvalid}, 0);

        // Reset while a core load is in flight.
        tick(); core_rd_req = 1; core_addr = 10'h005;
        tick(); reset = 0;
        @(negedge reloj); #1;
        chk("lit_rst_rdcore_rvalid", {31'b0, core_rvalid}, 0);
        tick(); reset = 1;
        @(negedge reloj); #1;
        chk("lit_reissue_enard", {31'b0, ram_ena_rd}, 1);
        tick();
        @(negedge reloj); #1;
        chk("lit_reissue_rdata", core_rdata, 32'hDEADBEEF);
        tick(); core_rd_req = 0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters.
  - The RISC-V core load/store port, which carries the core's read-enable, write-enable, ALU-computed address and store data.
  - A loader/debug port used to preload or inspect memory.
- Sequences the RAM's 1-cycle synchronous read latency.
- Drives the core stall and read-return signals.
- Sits between the core datapath and the data RAM inside the processor top.

Parameters:
- DW, 32, data word width.
- AW, 10, RAM word-address width.
- STARVE_MAX, 4, number of consecutive cycles the loader may lose arbitration before it is forced a grant; legal range is 1 or more.

Ports:
- reloj  in  1  clock; rising edge.
- reset  in  1  synchronous, active-low reset.
- core_rd_req  in  1  core load request.
- core_wr_req  in  1  core store request.
- core_addr  in  AW  core word address.
- core_wdata  in  DW  core store data.
- core_stall  out  1  core must hold its request and freeze the PC.
- core_rvalid  out  1  load data valid this cycle.
- core_rdata  out  DW  load data.
- ldr_req  in  1  loader request; held until ldr_ack.
- ldr_we  in  1  1 = write, 0 = read.
- ldr_addr  in  AW  loader word address.
- ldr_wdata  in  DW  loader write data.
- ldr_ack  out  1  one-cycle completion pulse.
- ldr_rdata  out  DW  loader read data, valid with ldr_ack when ldr_we = 0.
- ram_ena_rd  out  1  RAM read enable.
- ram_ena_wr  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data, valid the cycle after ram_ena_rd.

Behaviour:
- States: IDLE, RD_CORE, LDR_ACK.
  - State is registered.
  - RAM command outputs are combinational from state and inputs.
- Reset (reset = 0 at a rising edge):
  - State goes to IDLE; starve_cnt = 0.
  - All outputs are 0 while reset = 0, including RAM enables.
  - An in-flight read or ack is discarded; requesters must reissue.
- Core request: core_req = core_rd_req | core_wr_req. If both are high, the write wins and the read is ignored.
- IDLE arbitration, evaluated every cycle:
  - ldr_req & (!core_req | starve_cnt == STARVE_MAX) -> grant loader.
  - Else core_req -> grant core.
  - Else no RAM command.
- Granted RAM command: ram_addr and ram_din come from the granted requester; ram_ena_wr or ram_ena_rd is asserted in the grant cycle.
  - With no grant, ram_addr = 0, ram_din = 0, enables = 0.
- Core write: completes in the grant cycle with core_stall = 0; state stays IDLE. Back-to-back stores take 1 cycle each.
- Core read:
  - Grant cycle N: core_stall = 1; next state is RD_CORE.
  - Cycle N+1: core_rvalid = 1, core_rdata = ram_dout, core_stall = 0; next state is IDLE.
  - Load latency is 2 cycles, with no new RAM command in RD_CORE.
- Loader op:
  - Grant cycle N: next state is LDR_ACK.
  - Cycle N+1: ldr_ack = 1; ldr_rdata = ram_dout for reads, 0 for writes.
  - No RAM command is issued in LDR_ACK; next state is IDLE.
- core_stall = core_req & !(IDLE & core granted & write) & !(state == RD_CORE). The core therefore stalls while the loader owns the port.
- core_rdata = 0 when core_rvalid = 0. ldr_rdata = 0 when ldr_ack = 0.
- starve_cnt, updated in IDLE only:
  - +1 (saturating at STARVE_MAX) when ldr_req is high and the core is granted.
  - Cleared when the loader is granted or ldr_req = 0.
  - Held in the other states.
- Loader worst-case wait: STARVE_MAX core grants, plus up to one RD_CORE cycle after each.

Decomposition:
- Package riscv_mem_pkg:
  - arb_state_t enum {IDLE, RD_CORE, LDR_ACK}.
  - grant_t enum {GNT_NONE, GNT_CORE, GNT_LDR}.
  - Default DW/AW constants.
- Sub-module arb_starve_cnt: saturating counter with inc, clr and sat outputs, parameterised by STARVE_MAX.

Test Plan:
- Reset low for 3 cycles, with core_rd_req = 1 and ldr_req = 1 -> all outputs 0 throughout. First grant to the loader happens the cycle after release (core not requesting) or to the core (core requesting, starve_cnt = 0).
- Core write addr 0x005 data 0xDEADBEEF, then a core read of 0x005 -> write completes with stall = 0 in its cycle. The read asserts stall for 1 cycle, then core_rvalid = 1 with core_rdata = 0xDEADBEEF.
- Loader write 0x3FF = 0x12345678 with the core idle -> ram_ena_wr in cycle N, ldr_ack in N+1 with ldr_rdata = 0. A following loader read returns 0x12345678 with ack 2 cycles after req.
- Core issues continuous stores while ldr_req is held (STARVE_MAX = 4) -> 4 core grants, then a loader grant with core_stall = 1 for 2 cycles, then the core resumes. starve_cnt = 0 after the grant.
- core_rd_req and core_wr_req both high -> only ram_ena_wr is asserted and core_rvalid never pulses.
- Reset asserted in RD_CORE -> no core_rvalid; state IDLE after release; the reissued read returns correct data.
